wand_line_serial_rx: RTL and testbench
======================================

Name: wand_line_serial_rx

Overview:
- Receiver at the far end of a shared open-drain (wired-AND) single-wire serial line. The line idles high through a pull-up; any agent pulls it low.
- Samples the line, detects a start bit and recovers fixed-rate, LSB-first frames.
- Presents each received word to downstream logic through a valid/ready handshake, with framing-error and overrun flags.
- Acts as the reader for the transmit-side agents that drive the shared wand net.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per bit period; legal values are 4 or greater.
- DATA_W, 8, data bits per frame.

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- line_i  input  1  resolved wired-AND line level; asynchronous to clk; 1 = idle/released
- rx_data  output  DATA_W  last accepted word, LSB = first bit received
- rx_valid  output  1  rx_data holds an unconsumed word
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready at a clk edge
- frame_err  output  1  one-cycle pulse: stop bit sampled 0
- overrun  output  1  one-cycle pulse: a completed frame was dropped because the output was full

Behaviour:
- Reset values: rst_n low asynchronously clears all state and outputs.
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0.
  - Synchronizer flops = 1; FSM = IDLE; bit and cycle counters = 0.
- Synchronizer: two flops on line_i. All decisions use the synchronized value ls. Latency from line_i to ls is 2 clk.
- Frame format: one start bit (0), DATA_W data bits LSB first, one stop bit (1). No parity.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: cycle counter cnt=0. When ls==0, go to START with cnt=0.
  - START: increment cnt. When cnt==CLKS_PER_BIT/2-1 (integer divide), sample ls.
    - ls==0: go to DATA with cnt=0 and bit counter=0.
    - ls==1: go to IDLE. A short glitch is not a start bit.
  - DATA: increment cnt. When cnt==CLKS_PER_BIT-1, sample ls into the shift register MSB (shift right), clear cnt, increment the bit counter. After the DATA_W-th sample, go to STOP.
  - STOP: when cnt==CLKS_PER_BIT-1, sample ls.
    - ls==1: deliver the word and go to IDLE.
    - ls==0: pulse frame_err for one cycle, discard the word, go to BREAK.
  - BREAK: stay until ls==1, then go to IDLE. A held-low line never produces a new frame until it has been released.
- Delivery happens on the clk edge that samples a good stop bit:
  - rx_valid==0: load rx_data and set rx_valid=1. It is visible the cycle after the stop sample.
  - rx_valid==1 and rx_ready==1 on the same edge: the old word is consumed, the new word is loaded, and rx_valid stays 1. No overrun.
  - rx_valid==1 and rx_ready==0: new word dropped, rx_data unchanged, overrun pulses for one cycle.
- Handshake:
  - rx_valid and rx_data are stable until accepted.
  - On acceptance with no simultaneous delivery, rx_valid clears on that edge.
  - rx_ready is ignored while rx_valid==0.
- frame_err and overrun are never high in the same cycle.
- The receiver is always listening. Handshake state does not stall the FSM.
- Counters are sized to hold CLKS_PER_BIT-1 and DATA_W without wrap. No counter wraps in normal operation.
- Reset mid-frame abandons the frame. After release, a line still low is treated as a start candidate and is validated by the START mid-bit check.

Test Plan:
- CLKS_PER_BIT=16, DATA_W=8; send 0xA5 with correct bit timing; rx_ready=0.
  - Required: rx_data=0xA5, rx_valid=1, frame_err and overrun never asserted.
  - Then pulse rx_ready for 1 cycle: rx_valid=0 on the next cycle.
- Drive line_i low for 4 cycles, then high.
  - Required: FSM returns to IDLE, no rx_valid, no frame_err.
  - Then send 0x3C: rx_data=0x3C.
- Send 0x55 with stop bit 0, then hold the line low for 40 cycles, then release and send 0x81.
  - Required: exactly one frame_err pulse and no rx_valid for 0x55.
  - Then rx_data=0x81, rx_valid=1.
- Send 0x11 then 0x22 back-to-back with rx_ready=0.
  - Required: rx_data=0x11, rx_valid=1, one overrun pulse at the 0x22 stop sample.
- Hold rx_valid=1 (0x11) and raise rx_ready exactly on the 0x22 stop-sample edge.
  - Required: rx_data=0x22, rx_valid stays 1, no overrun.
- Assert rst_n low during data bit 3 of 0xF0.
  - Required: all outputs 0 immediately.
  - After release on an idle line, send 0x0F: rx_data=0x0F, no errors.

Source files
------------

// File: rtl/wand_line_serial_rx.sv
// Receiver for a wired-AND single-wire serial line: two-flop synchronizer, mid-bit
// sampling FSM, and a one-word valid/ready output slot with framing and overrun pulses.
module wand_line_serial_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_i,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t            r_state;
  logic              r_sync1;
  logic              r_sync2;
  logic [CNT_W-1:0]  r_cnt;
  logic [BIT_W-1:0]  r_bit;
  logic [DATA_W-1:0] r_shift;
  logic              w_ls;

  assign w_ls = r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      r_sync1   <= line_i;
      r_sync2   <= r_sync1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // A consume may be overridden below by a same-edge delivery.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_ls) begin
            r_state <= S_START;
          end
        end

        S_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= w_ls ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_ls, r_shift[DATA_W-1:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == LAST_BIT) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt <= '0;
            if (w_ls) begin
              r_state <= S_IDLE;
              if (!rx_valid || rx_ready) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              r_state   <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_BREAK: begin
          // Held-low line must be released before another start is accepted.
          r_cnt <= '0;
          if (w_ls) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wand_line_serial_rx.sv
// Bench for wand_line_serial_rx: vector table, directed corner sequences and
// randomized frames checked against a one-slot word model.
module tb_wand_line_serial_rx;

  localparam int CPB = 16;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          line_i = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  bit both_hi = 1'b0;

  wand_line_serial_rx #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_i    (line_i),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun)   ovr_cnt  <= ovr_cnt + 1;
    if (frame_err && overrun) both_hi <= 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          consume;
    logic [7:0]  data;
    bit          stop;
    int          gap;
    bit          exp_valid;
    logic [7:0]  exp_data;
    int          exp_ferr;
    int          exp_ovr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; every bit is held for CPB clocks, stop bit optionally extended low.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int hold);
    line_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      line_i = d[i];
      repeat (CPB) @(negedge clk);
    end
    line_i = stop;
    repeat (CPB + (stop ? 0 : hold)) @(negedge clk);
    line_i = 1'b1;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    int f0, o0;
    bit mdl_valid;
    logic [7:0] mdl_data;
    logic [7:0] d;
    bit stop, cons, exp_ovr, exp_ferr;
    int gap;

    vecs[0] = '{0, 8'hA5, 1, 4, 1, 8'hA5, 0, 0};
    vecs[1] = '{0, 8'h5A, 1, 4, 1, 8'hA5, 0, 1};
    vecs[2] = '{1, 8'h11, 1, 0, 1, 8'h11, 0, 0};
    vecs[3] = '{0, 8'h22, 1, 4, 1, 8'h11, 0, 1};
    vecs[4] = '{1, 8'hC3, 0, 4, 0, 8'h00, 1, 0};
    vecs[5] = '{0, 8'h3C, 1, 4, 1, 8'h3C, 0, 0};

    repeat (3) @(negedge clk);
    check("reset rx_valid", rx_valid, 0);
    check("reset rx_data", rx_data, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overrun", overrun, 0);
    rst_n = 1'b1;
    idle(4);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].consume) consume();
      f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(vecs[i].data, vecs[i].stop, 0);
      check($sformatf("vec%0d rx_valid", i), rx_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("vec%0d rx_data", i), rx_data, vecs[i].exp_data);
      check($sformatf("vec%0d frame_err pulses", i), ferr_cnt - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d overrun pulses", i), ovr_cnt - o0, vecs[i].exp_ovr);
      idle(vecs[i].gap);
    end

    // Single-cycle ready pulse empties the slot on the following cycle.
    consume();
    check("consume rx_valid", rx_valid, 0);

    // Short low glitch is rejected by the mid-bit start check.
    f0 = ferr_cnt;
    line_i = 1'b0;
    idle(4);
    line_i = 1'b1;
    idle(30);
    check("glitch rx_valid", rx_valid, 0);
    check("glitch frame_err", ferr_cnt - f0, 0);
    send_frame(8'h3C, 1'b1, 0);
    idle(2);
    check("post-glitch rx_data", rx_data, 8'h3C);
    check("post-glitch rx_valid", rx_valid, 1);

    // Bad stop followed by a 40-cycle held-low break.
    consume();
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 40);
    idle(4);
    check("break frame_err pulses", ferr_cnt - f0, 1);
    check("break rx_valid", rx_valid, 0);
    f0 = ferr_cnt;
    send_frame(8'h81, 1'b1, 0);
    idle(2);
    check("after-break rx_data", rx_data, 8'h81);
    check("after-break rx_valid", rx_valid, 1);
    check("after-break frame_err", ferr_cnt - f0, 0);

    // Back-to-back frames with the slot full.
    consume();
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    idle(2);
    check("b2b rx_data", rx_data, 8'h11);
    check("b2b rx_valid", rx_valid, 1);
    check("b2b overrun pulses", ovr_cnt - o0, 1);

    // Ready raised exactly on the stop-sample edge of the next frame.
    o0 = ovr_cnt;
    fork
      send_frame(8'h22, 1'b1, 0);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    idle(2);
    check("simul rx_data", rx_data, 8'h22);
    check("simul rx_valid", rx_valid, 1);
    check("simul overrun", ovr_cnt - o0, 0);

    // Asynchronous reset during data bit 3 of 0xF0.
    fork
      send_frame(8'hF0, 1'b1, 0);
      begin
        repeat (70) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset rx_valid", rx_valid, 0);
        check("midreset rx_data", rx_data, 0);
        check("midreset frame_err", frame_err, 0);
        check("midreset overrun", overrun, 0);
      end
    join
    idle(2);
    rst_n = 1'b1;
    idle(5);
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h0F, 1'b1, 0);
    idle(2);
    check("post-reset rx_data", rx_data, 8'h0F);
    check("post-reset rx_valid", rx_valid, 1);
    check("post-reset errors", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

    // Randomized frames against the one-slot model.
    consume();
    check("rand start rx_valid", rx_valid, 0);
    mdl_valid = 1'b0;
    mdl_data  = 8'h00;
    for (int n = 0; n < 25; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      cons = 1'($urandom_range(0, 1));
      gap  = $urandom_range(1, 6);
      if (cons) begin
        consume();
        mdl_valid = 1'b0;
      end
      exp_ovr = 1'b0;
      exp_ferr = 1'b0;
      if (!stop) exp_ferr = 1'b1;
      else if (mdl_valid) exp_ovr = 1'b1;
      else begin
        mdl_valid = 1'b1;
        mdl_data  = d;
      end
      f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(d, stop, 0);
      idle(gap);
      check($sformatf("rand%0d rx_valid", n), rx_valid, mdl_valid);
      if (mdl_valid) check($sformatf("rand%0d rx_data", n), rx_data, mdl_data);
      check($sformatf("rand%0d frame_err", n), ferr_cnt - f0, exp_ferr);
      check($sformatf("rand%0d overrun", n), ovr_cnt - o0, exp_ovr);
    end

    check("frame_err/overrun exclusive", both_hi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
